// File: rtl/dac_pattern_loader.sv
// ---------------------------------------------------------------------------
// dac_pattern_loader
//   Double-buffered pattern loader for the current-steering DAC cell array.
//   A shadow chain is loaded serially LANES bits per shift, then committed to
//   the active cell-state register behind a break-before-make enable window
//   (enables low -> parallel load -> enables low -> enables back), so the
//   array never sees a half-updated pattern. Readback copies the active
//   pattern into the chain.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   sdi[LANES]            serial beat; sdi[LANES-1] is the oldest bit
//   shift                 shift one beat into the chain (IDLE only)
//   commit                request chain -> active state (needs a full frame)
//   readback              copy active state -> chain (IDLE only)
//   en_req                user enable for the DAC array
//   sdo[LANES]            top beat of the chain
//   state_on/state_onb    active pattern and its complement
//   en_p/en_n             registered replicated enable and its complement
//   busy                  commit sequence in progress
//   frame_full            a full frame has been shifted since commit/readback
//   frame_err             sticky: a commit was rejected (incomplete frame)
// ---------------------------------------------------------------------------
module dac_pattern_loader #(
    parameter int N_CELLS    = 128,
    parameter int LANES      = 1,
    parameter int EN_WIDTH   = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [LANES-1:0]    sdi,
    input  logic                shift,
    input  logic                commit,
    input  logic                readback,
    input  logic                en_req,
    output logic [LANES-1:0]    sdo,
    output logic [N_CELLS-1:0]  state_on,
    output logic [N_CELLS-1:0]  state_onb,
    output logic [EN_WIDTH-1:0] en_p,
    output logic [EN_WIDTH-1:0] en_n,
    output logic                busy,
    output logic                frame_full,
    output logic                frame_err
);

    localparam int BEATS = N_CELLS / LANES;
    localparam int CW    = $clog2(BEATS + 1);
    localparam int TW    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [CW-1:0] BEATS_C    = CW'(BEATS);
    localparam logic [TW-1:0] TIMER_INIT = TW'(SETTLE_CYC - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BLANK   = 2'd1;
    localparam logic [1:0] S_LOAD    = 2'd2;
    localparam logic [1:0] S_UNBLANK = 2'd3;

    logic [1:0]         fsm, fsm_nxt;
    logic [TW-1:0]      timer;
    logic [CW-1:0]      count;
    logic [N_CELLS-1:0] chain;

    assign frame_full = (count == BEATS_C);
    assign busy       = (fsm != S_IDLE);
    assign sdo        = chain[N_CELLS-1 -: LANES];
    assign state_onb  = ~state_on;
    assign en_n       = ~en_p;

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            S_IDLE:    if (commit && frame_full) fsm_nxt = S_BLANK;
            S_BLANK:   if (timer == '0) fsm_nxt = S_LOAD;
            S_LOAD:    fsm_nxt = S_UNBLANK;
            S_UNBLANK: if (timer == '0) fsm_nxt = S_IDLE;
            default:   fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= S_IDLE;
            timer     <= '0;
            count     <= '0;
            chain     <= '0;
            state_on  <= '0;
            en_p      <= '0;
            frame_err <= 1'b0;
        end else begin
            fsm  <= fsm_nxt;
            // Keyed off the next state so the enables drop on the same edge
            // the sequence starts and return only once it is back in IDLE.
            en_p <= {EN_WIDTH{en_req && (fsm_nxt == S_IDLE)}};
            case (fsm)
                S_IDLE: begin
                    // commit > readback > shift; losers are dropped.
                    if (commit) begin
                        if (frame_full) begin
                            timer     <= TIMER_INIT;
                            frame_err <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else if (readback) begin
                        chain <= state_on;
                        count <= BEATS_C;
                    end else if (shift) begin
                        chain <= {chain[N_CELLS-LANES-1:0], sdi};
                        if (!frame_full) count <= count + CW'(1);
                    end
                end
                S_BLANK: begin
                    if (timer != '0) timer <= timer - TW'(1);
                end
                S_LOAD: begin
                    // Single-cycle parallel load: the pattern is never torn.
                    state_on <= chain;
                    count    <= '0;
                    timer    <= TIMER_INIT;
                end
                S_UNBLANK: begin
                    if (timer != '0) timer <= timer - TW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_pattern_loader.sv
// ---------------------------------------------------------------------------
// tb_dac_pattern_loader
//   Two instances (LANES=1 and LANES=4) share clock, reset and en_req.
//   Reference model is transaction level: a shadow word, an active word, a
//   beat count and a sticky error per instance, updated per directed step.
// ---------------------------------------------------------------------------
module tb_dac_pattern_loader;

    localparam int N  = 128;
    localparam int S  = 2;
    localparam int EW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en_req = 1'b0;

    logic          a_sdi = 1'b0, a_shift = 1'b0, a_commit = 1'b0, a_readback = 1'b0;
    logic          a_sdo;
    logic [N-1:0]  a_on, a_onb;
    logic [EW-1:0] a_enp, a_enn;
    logic          a_busy, a_full, a_err;

    logic [3:0]    b_sdi = 4'h0;
    logic          b_shift = 1'b0, b_commit = 1'b0, b_readback = 1'b0;
    logic [3:0]    b_sdo;
    logic [N-1:0]  b_on, b_onb;
    logic [EW-1:0] b_enp, b_enn;
    logic          b_busy, b_full, b_err;

    dac_pattern_loader #(.N_CELLS(N), .LANES(1), .EN_WIDTH(EW), .SETTLE_CYC(S)) u_a (
        .clk(clk), .rst_n(rst_n), .sdi(a_sdi), .shift(a_shift), .commit(a_commit),
        .readback(a_readback), .en_req(en_req), .sdo(a_sdo), .state_on(a_on),
        .state_onb(a_onb), .en_p(a_enp), .en_n(a_enn), .busy(a_busy),
        .frame_full(a_full), .frame_err(a_err));

    dac_pattern_loader #(.N_CELLS(N), .LANES(4), .EN_WIDTH(EW), .SETTLE_CYC(S)) u_b (
        .clk(clk), .rst_n(rst_n), .sdi(b_sdi), .shift(b_shift), .commit(b_commit),
        .readback(b_readback), .en_req(en_req), .sdo(b_sdo), .state_on(b_on),
        .state_onb(b_onb), .en_p(b_enp), .en_n(b_enn), .busy(b_busy),
        .frame_full(b_full), .frame_err(b_err));

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    // reference model, index 0 = LANES 1, index 1 = LANES 4
    logic [N-1:0] m_chain [2];
    logic [N-1:0] m_state [2];
    int           m_cnt   [2];
    logic         m_err   [2];

    task automatic chk(string tag, logic [N-1:0] obs, logic [N-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int beats_of(int s);
        return (s == 0) ? N : N / 4;
    endfunction
    function automatic logic busy_of(int s);  return (s == 0) ? a_busy : b_busy; endfunction
    function automatic logic full_of(int s);  return (s == 0) ? a_full : b_full; endfunction
    function automatic logic err_of(int s);   return (s == 0) ? a_err  : b_err;  endfunction
    function automatic logic [N-1:0] on_of(int s);   return (s == 0) ? a_on  : b_on;  endfunction
    function automatic logic [EW-1:0] enp_of(int s); return (s == 0) ? a_enp : b_enp; endfunction
    function automatic logic [EW-1:0] enn_of(int s); return (s == 0) ? a_enn : b_enn; endfunction

    function automatic void model_reset();
        for (int s = 0; s < 2; s++) begin
            m_chain[s] = '0; m_state[s] = '0; m_cnt[s] = 0; m_err[s] = 1'b0;
        end
    endfunction

    // One beat into instance s; the newest bits land at the chain bottom.
    task automatic shift_beat(int s, logic [3:0] d);
        if (s == 0) begin a_sdi = d[0]; a_shift = 1'b1; end
        else        begin b_sdi = d;    b_shift = 1'b1; end
        tick();
        a_shift = 1'b0; b_shift = 1'b0;
        if (s == 0) m_chain[0] = (m_chain[0] << 1) | N'(d[0]);
        else        m_chain[1] = (m_chain[1] << 4) | N'(d);
        if (m_cnt[s] < beats_of(s)) m_cnt[s]++;
    endtask

    task automatic readback_op(int s);
        if (s == 0) a_readback = 1'b1; else b_readback = 1'b1;
        tick();
        a_readback = 1'b0; b_readback = 1'b0;
        m_chain[s] = m_state[s];
        m_cnt[s]   = beats_of(s);
    endtask

    // Shift the whole LANES=1 chain out through sdo while zeros go in.
    task automatic readout_a(output logic [N-1:0] got);
        got = '0;
        for (int i = 0; i < N; i++) begin
            got = {got[N-2:0], a_sdo};
            shift_beat(0, 4'h0);
        end
    endtask

    task automatic commit_seq(int s, string tag);
        int n, low;
        logic accept;
        accept = (m_cnt[s] == beats_of(s));
        if (s == 0) a_commit = 1'b1; else b_commit = 1'b1;
        tick();
        a_commit = 1'b0; b_commit = 1'b0;
        if (!accept) begin
            m_err[s] = 1'b1;
            chk($sformatf("%s.rej_busy", tag), busy_of(s), 0);
            chk($sformatf("%s.rej_err", tag), err_of(s), m_err[s]);
            chk($sformatf("%s.rej_state", tag), on_of(s), m_state[s]);
            return;
        end
        n = 0; low = 0;
        while (busy_of(s) && n < 50) begin
            if (enp_of(s) == '0) low++;
            n++;
            tick();
        end
        m_state[s] = m_chain[s];
        m_cnt[s]   = 0;
        m_err[s]   = 1'b0;
        chk($sformatf("%s.busy_cycles", tag), n, 2 * S + 1);
        chk($sformatf("%s.en_low_in_busy", tag), low, n);
        chk($sformatf("%s.state_on", tag), on_of(s), m_state[s]);
        chk($sformatf("%s.full_after", tag), full_of(s), 0);
        chk($sformatf("%s.err_after", tag), err_of(s), m_err[s]);
        tick();
        chk($sformatf("%s.en_p_after", tag), enp_of(s), en_req ? {EW{1'b1}} : '0);
        chk($sformatf("%s.en_n_after", tag), enn_of(s), en_req ? '0 : {EW{1'b1}});
    endtask

    task automatic check_reset(string tag);
        chk($sformatf("%s.a_on", tag), a_on, '0);
        chk($sformatf("%s.a_onb", tag), a_onb, {N{1'b1}});
        chk($sformatf("%s.a_enp", tag), a_enp, '0);
        chk($sformatf("%s.a_enn", tag), a_enn, {EW{1'b1}});
        chk($sformatf("%s.a_flags", tag), {a_busy, a_full, a_err, a_sdo}, '0);
        chk($sformatf("%s.b_on", tag), b_on, '0);
        chk($sformatf("%s.b_flags", tag), {b_busy, b_full, b_err, b_sdo, b_enp}, '0);
        chk($sformatf("%s.b_enn", tag), b_enn, {EW{1'b1}});
    endtask

    initial begin
        logic [6:0]   lfsr;
        logic         bit_v;
        logic [3:0]   nib;
        logic [N-1:0] got, exp;
        int           n, bad;

        model_reset();
        #2;
        check_reset("reset");
        @(negedge clk);
        rst_n  = 1'b1;
        en_req = 1'b1;
        tick();

        // T1: PRBS7 frame on LANES=1, then commit
        lfsr = 7'($urandom_range(1, 127));
        for (int i = 0; i < N; i++) begin
            bit_v = lfsr[6] ^ lfsr[5];
            lfsr  = {lfsr[5:0], bit_v};
            shift_beat(0, {3'b0, bit_v});
        end
        chk("T1.full", a_full, 1);
        commit_seq(0, "T1");

        // T2: short frame rejected, completing it is accepted
        for (int i = 0; i < 100; i++) shift_beat(0, 4'($urandom_range(0, 1)));
        chk("T2.not_full", a_full, 0);
        commit_seq(0, "T2a");
        for (int i = 0; i < 28; i++) shift_beat(0, 4'($urandom_range(0, 1)));
        commit_seq(0, "T2b");

        // T3: LANES=4, 32 beats of 4'hA, sdo tracking the top nibble
        bad = 0;
        for (int i = 0; i < N / 4; i++) begin
            if (i == N / 4 - 1) chk("T3.full_before_last", b_full, 0);
            shift_beat(1, 4'hA);
            if (b_sdo !== m_chain[1][N-1 -: 4]) bad++;
        end
        chk("T3.sdo_track", bad, 0);
        chk("T3.full", b_full, 1);
        commit_seq(1, "T3");
        chk("T3.pattern", b_on, {32{4'hA}});

        // T3b: random nibbles, overrun past a full frame, sdo checked per beat
        bad = 0;
        for (int i = 0; i < N / 4 + 8; i++) begin
            nib = 4'($urandom);
            shift_beat(1, nib);
            if (b_sdo !== m_chain[1][N-1 -: 4]) bad++;
        end
        chk("T3b.sdo_track", bad, 0);
        commit_seq(1, "T3b");

        // T4: commit+shift+readback together; shifts during busy dropped
        for (int i = 0; i < N; i++) shift_beat(0, 4'($urandom_range(0, 1)));
        exp = m_chain[0];
        a_commit = 1'b1; a_shift = 1'b1; a_readback = 1'b1; a_sdi = 1'($urandom);
        tick();
        a_commit = 1'b0; a_readback = 1'b0;
        n = 0;
        while (a_busy && n < 50) begin
            a_sdi = 1'($urandom);
            n++;
            tick();
        end
        a_shift = 1'b0;
        m_state[0] = exp; m_cnt[0] = 0;
        chk("T4.busy_cycles", n, 2 * S + 1);
        chk("T4.state_on", a_on, exp);
        chk("T4.count_held", a_full, 0);
        chk("T4.err", a_err, 0);
        readout_a(got);
        chk("T4.chain_unchanged", got, exp);

        // T5: readback into chain, then re-commit the same pattern
        readback_op(0);
        chk("T5.full_after_rb", a_full, 1);
        readout_a(got);
        chk("T5.readout", got, m_state[0]);
        readback_op(0);
        exp = m_state[0];
        commit_seq(0, "T5");
        chk("T5.same_pattern", a_on, exp);

        // en_req low keeps the enables off
        en_req = 1'b0;
        tick();
        chk("EN.off_p", a_enp, '0);
        chk("EN.off_n", a_enn, {EW{1'b1}});
        en_req = 1'b1;
        tick();
        chk("EN.on_p", a_enp, {EW{1'b1}});

        // T6: reset in BLANK (1 cycle in) and in LOAD (3 cycles in)
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < N; i++) shift_beat(0, 4'($urandom_range(0, 1)));
            a_commit = 1'b1;
            tick();
            a_commit = 1'b0;
            if (ph == 1) begin tick(); tick(); end
            chk($sformatf("T6.%0d.busy_before", ph), a_busy, 1);
            rst_n = 1'b0;
            #1;
            model_reset();
            check_reset($sformatf("T6.%0d", ph));
            #1;
            rst_n = 1'b1;
            tick();
            for (int i = 0; i < N; i++) shift_beat(0, 4'($urandom_range(0, 1)));
            commit_seq(0, $sformatf("T6.%0d.reload", ph));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
